slave_sel_ctrl: RTL and testbench

Response-path controller for the serial system bus: receives a 2-bit serial device ID from the master, enables the addressed slave (0..2), and drives the select of the 3-to-1 slave-response multiplexer for the whole transaction. It enforces a per-phase timeout and flags an error for invalid IDs. It sits between the master port and the slave-response `mux3`: its `sel` output connects directly to the mux `sel`.

---
 rtl/bus_ctrl_pkg.sv | 27 ++
 rtl/bus_timer.sv | 26 ++
 rtl/slave_sel_ctrl.sv | 107 ++++++++++
 tb/tb_slave_sel_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared state, device-ID and response-mux select encodings for the serial bus controllers
package bus_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] SLV0        = 2'b00;
    localparam logic [1:0] SLV1        = 2'b01;
    localparam logic [1:0] SLV2        = 2'b10;
    localparam logic [1:0] SLV_INVALID = 2'b11;

    localparam logic [1:0] SEL_S0 = SLV0;
    localparam logic [1:0] SEL_S1 = SLV1;
    localparam logic [1:0] SEL_S2 = SLV2;

    function automatic logic [2:0] slv_onehot(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

    function automatic logic [1:0] id2sel(input logic [1:0] id);
        return id == SLV1 ? SEL_S1 : id == SLV2 ? SEL_S2 : SEL_S0;
    endfunction
endpackage

// File: rtl/bus_timer.sv
// bus_timer: clearable up-counter that flags expiry when the count reaches TIMEOUT-1
module bus_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // saturates at LAST so a stalled owner never wraps back to a fresh budget
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count_q <= '0;
        else if (clear)
            count_q <= '0;
        else if (en && count_q != LAST)
            count_q <= count_q + 1'b1;

    assign expire = count_q == LAST;
endmodule

// File: rtl/slave_sel_ctrl.sv
// slave_sel_ctrl: decodes the serial device ID, enables the addressed slave and holds the response-mux select
module slave_sel_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m_valid,
    input  logic       m_addr,
    input  logic [2:0] s_ready,
    input  logic [2:0] s_done,
    output logic [1:0] sel,
    output logic [2:0] s_en,
    output logic       busy,
    output logic       m_grant,
    output logic       m_err
);
    state_e     state_q;
    logic       id_hi_q, busy_q, grant_q, err_q;
    logic [1:0] sel_q, id_d;
    logic [2:0] s_en_q;
    logic       rdy, done, tmr_clr, tmr_en, expire;

    // s_en_q is one-hot on the decoded ID in SETUP/ACTIVE, so it masks out other slaves
    always_comb begin
        id_d    = {id_hi_q, m_addr};
        rdy     = |(s_ready & s_en_q);
        done    = |(s_done & s_en_q);
        tmr_en  = state_q == ST_SETUP || state_q == ST_ACTIVE;
        tmr_clr = (state_q == ST_ADDR && id_d != SLV_INVALID) || (state_q == ST_SETUP && rdy);
    end

    bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (tmr_clr),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_hi_q <= 1'b0;
            sel_q   <= SEL_S0;
            s_en_q  <= 3'b000;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE:
                    if (m_valid) begin
                        id_hi_q <= m_addr;
                        busy_q  <= 1'b1;
                        state_q <= ST_ADDR;
                    end
                ST_ADDR:
                    if (id_d == SLV_INVALID) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        sel_q   <= id2sel(id_d);
                        s_en_q  <= slv_onehot(id_d);
                        state_q <= ST_SETUP;
                    end
                ST_SETUP:
                    if (rdy) begin
                        grant_q <= 1'b1;
                        state_q <= ST_ACTIVE;
                    end else if (expire) begin
                        err_q   <= 1'b1;
                        s_en_q  <= 3'b000;
                        state_q <= ST_ERR;
                    end
                ST_ACTIVE:
                    if (done) begin
                        s_en_q  <= 3'b000;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (expire) begin
                        err_q   <= 1'b1;
                        s_en_q  <= 3'b000;
                        state_q <= ST_ERR;
                    end
                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    s_en_q  <= 3'b000;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel     = sel_q;
    assign s_en    = s_en_q;
    assign busy    = busy_q;
    assign m_grant = grant_q;
    assign m_err   = err_q;
endmodule

// File: tb/tb_slave_sel_ctrl.sv
// tb_slave_sel_ctrl: directed transactions with a scoreboard of expected grant/error/idle events
module tb_slave_sel_ctrl;
    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] sel;
        logic [2:0] en;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, m_valid = 1'b0, m_addr = 1'b0;
    logic [2:0] s_ready = 3'b000, s_done = 3'b000;
    logic [1:0] sel;
    logic [2:0] s_en;
    logic       busy, m_grant, m_err;
    int         cyc = 0, checks = 0, failures = 0, kind;
    logic       mon_on = 1'b1, busy_p = 1'b0;
    exp_t       exp_q[$];
    exp_t       e;

    slave_sel_ctrl #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .s_ready (s_ready),
        .s_done  (s_done),
        .sel     (sel),
        .s_en    (s_en),
        .busy    (busy),
        .m_grant (m_grant),
        .m_err   (m_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic [1:0] s, input logic [2:0] en);
        exp_t x;
        x.kind = k;
        x.cyc  = c;
        x.sel  = s;
        x.en   = en;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kinds: 0 = m_grant, 1 = m_err, 2 = busy falling (back in IDLE)
    always @(negedge clk) begin
        if (mon_on && (m_grant || m_err || (busy_p && !busy))) begin
            kind = m_grant ? 0 : m_err ? 1 : 2;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event: unexpected kind=%0d at cycle %0d", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != kind || e.cyc != cyc || e.sel != sel || e.en != s_en) begin
                    failures++;
                    $display("FAIL event: got kind=%0d cyc=%0d sel=%b s_en=%b expected kind=%0d cyc=%0d sel=%b s_en=%b",
                             kind, cyc, sel, s_en, e.kind, e.cyc, e.sel, e.en);
                end
            end
        end
        busy_p = busy;
    end

    // rel-cycle offsets: rdy/done/nz = -1 when absent; nz injects other-slave ready/done and a stray m_valid
    task automatic run(input logic [1:0] id, input int rdy, input int done, input int nz, input int grant,
                       input int err, input int idle, input logic [1:0] xs, input logic [2:0] xe);
        int c0;
        c0 = cyc;
        if (grant >= 0) push(0, c0 + grant, xs, xe);
        if (err >= 0) push(1, c0 + err, xs, 3'b000);
        push(2, c0 + idle, xs, 3'b000);
        for (int r = 0; r < idle; r++) begin
            m_valid = (r == 0) || (r == nz);
            m_addr  = r == 0 ? id[1] : r == 1 ? id[0] : r == nz;
            s_ready = r == rdy ? xe : r == nz ? ~xe : 3'b000;
            s_done  = r == done ? xe : r == nz ? ~xe : 3'b000;
            if (r == 2) begin
                chk("sel_c2", int'(sel), int'(xs));
                chk("s_en_c2", int'(s_en), int'(xe));
            end
            step();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_s_en", int'(s_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(m_grant), 0);
        chk("rst_err", int'(m_err), 0);
        #3 rst = 1'b0;
        step();
        //   id     rdy done nz  grant err idle sel    s_en
        run(2'b01,  2,  5, -1,  3, -1,  6, 2'b01, 3'b010);
        run(2'b11, -1, -1, -1, -1,  2,  3, 2'b01, 3'b000);
        run(2'b10, -1, -1, -1, -1,  6,  7, 2'b10, 3'b100);
        run(2'b10,  5,  7, -1,  6, -1,  8, 2'b10, 3'b100);
        run(2'b00,  2,  5,  4,  3, -1,  6, 2'b00, 3'b001);
        run(2'b10,  3,  6, -1,  4, -1,  7, 2'b10, 3'b100);
        run(2'b00,  2, -1,  5,  3,  7,  8, 2'b00, 3'b001);
        run(2'b01,  2,  6, -1,  3, -1,  7, 2'b01, 3'b010);
        push(0, cyc + 3, 2'b10, 3'b100);
        m_valid = 1'b1;
        m_addr  = 1'b1;
        step();
        m_valid = 1'b0;
        m_addr  = 1'b0;
        step();
        s_ready = 3'b100;
        step();
        s_ready = 3'b000;
        step();
        #2;
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_s_en", int'(s_en), 0);
        chk("arst_sel", int'(sel), 0);
        chk("arst_busy", int'(busy), 0);
        #2 rst = 1'b0;
        step();
        mon_on = 1'b1;
        run(2'b01,  2,  4, -1,  3, -1,  5, 2'b01, 3'b010);
        m_valid = 1'b0;
        m_addr  = 1'b0;
        s_ready = 3'b000;
        s_done  = 3'b000;
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
